fp_multiply_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point multiplier, the next generation of the single-precision float_multiply. Exponent and mantissa widths are generic, with binary32 as the default. Operands enter through a valid/ready handshake, pass a fixed 3-stage pipeline and leave through a valid/ready handshake with exception flags. It sits between operand-fetch logic and any consumer that can apply backpressure.

---
 rtl/fp_multiply_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_fp_multiply_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_multiply_pipe.sv
// Pipelined floating-point multiplier with generic exponent/fraction widths.
// Valid/ready at both ends; DAZ on input, flush-to-zero on underflow, round-to-nearest-even.
module fp_multiply_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] IN1,
  input  logic [EXP_W+MAN_W:0] IN2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] OUT,
  output logic [3:0]           flags
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int EW     = EXP_W + 2;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);

  typedef enum logic [1:0] {K_NUM, K_NAN, K_INF, K_ZERO} kind_t;

  // Returns {carry, fraction}; a carry means the significand rolled over to 2.0.
  function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] frac,
                                               input logic guard, input logic sticky);
    logic inc;
    inc = guard & (sticky | frac[0]);
    return {1'b0, frac} + {{MAN_W{1'b0}}, inc};
  endfunction

  // Returns {flags, word}; saturates to inf on overflow and flushes to zero on underflow.
  function automatic logic [W+3:0] pack_sat(input logic sign, input kind_t kind,
                                            input logic invalid,
                                            input logic signed [EW-1:0] e_fin,
                                            input logic [MAN_W-1:0] frac,
                                            input logic inexact);
    logic [W-1:0] qnan_w, inf_w, zero_w;
    logic [W+3:0] res;
    qnan_w = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    inf_w  = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    zero_w = {sign, {(W-1){1'b0}}};
    case (kind)
      K_NAN:   res = {invalid, 3'b000, qnan_w};
      K_INF:   res = {4'b0000, inf_w};
      K_ZERO:  res = {4'b0000, zero_w};
      default: begin
        if (e_fin >= EXP_MAX)       res = {4'b0101, inf_w};
        else if (e_fin <= EXP_ZERO) res = {4'b0011, zero_w};
        else                        res = {3'b000, inexact, sign, e_fin[EXP_W-1:0], frac};
      end
    endcase
    return res;
  endfunction

  logic advance;

  logic                    vld_p0_d, vld_p0_q, sign_p0_d, sign_p0_q, inv_p0_d, inv_p0_q;
  kind_t                   kind_p0_d, kind_p0_q;
  logic signed [EW-1:0]    exp_p0_d, exp_p0_q;
  logic [SIG_W-1:0]        siga_p0_d, siga_p0_q, sigb_p0_d, sigb_p0_q;

  logic                    vld_p1_d, vld_p1_q, sign_p1_d, sign_p1_q, inv_p1_d, inv_p1_q;
  kind_t                   kind_p1_d, kind_p1_q;
  logic signed [EW-1:0]    exp_p1_d, exp_p1_q;
  logic [PROD_W-1:0]       prod_p1_d, prod_p1_q;

  logic                    vld_p2_d, vld_p2_q, sign_p2_d, sign_p2_q, inv_p2_d, inv_p2_q;
  kind_t                   kind_p2_d, kind_p2_q;
  logic signed [EW-1:0]    exp_p2_d, exp_p2_q;
  logic [MAN_W-1:0]        frac_p2_d, frac_p2_q;
  logic                    guard_p2_d, guard_p2_q, sticky_p2_d, sticky_p2_q;

  logic                    out_valid_d, out_valid_q;
  logic [W-1:0]            out_d, out_q;
  logic [3:0]              flags_d, flags_q;

  logic                    sa, sb;
  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        fa, fb;
  logic                    zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [MAN_W:0]          rnd;
  logic signed [EW-1:0]    exp_fin;
  logic [W+3:0]            res;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign OUT       = out_q;
  assign flags     = flags_q;

  // Stage 1: unpack, classify, exponent sum -> p0
  always_comb begin
    {sa, ea, fa} = IN1;
    {sb, eb, fb} = IN2;
    zero_a = (ea == '0);
    zero_b = (eb == '0);
    inf_a  = (ea == '1) && (fa == '0);
    inf_b  = (eb == '1) && (fb == '0);
    nan_a  = (ea == '1) && (fa != '0);
    nan_b  = (eb == '1) && (fb != '0);
    vld_p0_d  = vld_p0_q;
    sign_p0_d = sign_p0_q;
    inv_p0_d  = inv_p0_q;
    kind_p0_d = kind_p0_q;
    exp_p0_d  = exp_p0_q;
    siga_p0_d = siga_p0_q;
    sigb_p0_d = sigb_p0_q;
    if (advance) begin
      vld_p0_d  = in_valid;
      sign_p0_d = sa ^ sb;
      inv_p0_d  = 1'b0;
      if (nan_a || nan_b) begin
        kind_p0_d = K_NAN;
      end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
        kind_p0_d = K_NAN;
        inv_p0_d  = 1'b1;
      end else if (inf_a || inf_b) begin
        kind_p0_d = K_INF;
      end else if (zero_a || zero_b) begin
        kind_p0_d = K_ZERO;
      end else begin
        kind_p0_d = K_NUM;
      end
      exp_p0_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
      siga_p0_d = {1'b1, fa};
      sigb_p0_d = {1'b1, fb};
    end
  end

  // Stage 2: significand product -> p1
  always_comb begin
    vld_p1_d  = vld_p1_q;
    sign_p1_d = sign_p1_q;
    inv_p1_d  = inv_p1_q;
    kind_p1_d = kind_p1_q;
    exp_p1_d  = exp_p1_q;
    prod_p1_d = prod_p1_q;
    if (advance) begin
      vld_p1_d  = vld_p0_q;
      sign_p1_d = sign_p0_q;
      inv_p1_d  = inv_p0_q;
      kind_p1_d = kind_p0_q;
      exp_p1_d  = exp_p0_q;
      prod_p1_d = PROD_W'(siga_p0_q) * PROD_W'(sigb_p0_q);
    end
  end

  // Stage 3a: normalise, extract guard and sticky -> p2
  always_comb begin
    vld_p2_d    = vld_p2_q;
    sign_p2_d   = sign_p2_q;
    inv_p2_d    = inv_p2_q;
    kind_p2_d   = kind_p2_q;
    exp_p2_d    = exp_p2_q;
    frac_p2_d   = frac_p2_q;
    guard_p2_d  = guard_p2_q;
    sticky_p2_d = sticky_p2_q;
    if (advance) begin
      vld_p2_d  = vld_p1_q;
      sign_p2_d = sign_p1_q;
      inv_p2_d  = inv_p1_q;
      kind_p2_d = kind_p1_q;
      if (prod_p1_q[PROD_W-1]) begin
        exp_p2_d    = exp_p1_q + EXP_ONE;
        frac_p2_d   = prod_p1_q[PROD_W-2 -: MAN_W];
        guard_p2_d  = prod_p1_q[MAN_W];
        sticky_p2_d = |prod_p1_q[MAN_W-1:0];
      end else begin
        exp_p2_d    = exp_p1_q;
        frac_p2_d   = prod_p1_q[PROD_W-3 -: MAN_W];
        guard_p2_d  = prod_p1_q[MAN_W-1];
        sticky_p2_d = |prod_p1_q[MAN_W-2:0];
      end
    end
  end

  // Stage 3b: round, renormalise, pack -> output registers
  always_comb begin
    rnd         = round_rne(frac_p2_q, guard_p2_q, sticky_p2_q);
    exp_fin     = exp_p2_q + (rnd[MAN_W] ? EXP_ONE : EXP_ZERO);
    res         = pack_sat(sign_p2_q, kind_p2_q, inv_p2_q, exp_fin, rnd[MAN_W-1:0],
                           guard_p2_q | sticky_p2_q);
    out_valid_d = out_valid_q;
    out_d       = out_q;
    flags_d     = flags_q;
    if (advance) begin
      out_valid_d = vld_p2_q;
      if (vld_p2_q) {flags_d, out_d} = res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
    end else begin
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    sign_p0_q   <= sign_p0_d;
    inv_p0_q    <= inv_p0_d;
    kind_p0_q   <= kind_p0_d;
    exp_p0_q    <= exp_p0_d;
    siga_p0_q   <= siga_p0_d;
    sigb_p0_q   <= sigb_p0_d;
    sign_p1_q   <= sign_p1_d;
    inv_p1_q    <= inv_p1_d;
    kind_p1_q   <= kind_p1_d;
    exp_p1_q    <= exp_p1_d;
    prod_p1_q   <= prod_p1_d;
    sign_p2_q   <= sign_p2_d;
    inv_p2_q    <= inv_p2_d;
    kind_p2_q   <= kind_p2_d;
    exp_p2_q    <= exp_p2_d;
    frac_p2_q   <= frac_p2_d;
    guard_p2_q  <= guard_p2_d;
    sticky_p2_q <= sticky_p2_d;
  end

endmodule

// File: tb/tb_fp_multiply_pipe.sv
// Bench for fp_multiply_pipe: binary32 and a 5/10 narrow instance, directed cases,
// backpressure stream, mid-flight reset and random sweeps against a real-arithmetic model.
`timescale 1ns/1ps
module tb_fp_multiply_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_vld, a_irdy, a_ovld, a_ordy;
  logic [31:0] a_in1, a_in2, a_out;
  logic [3:0]  a_flags;
  logic        b_vld, b_irdy, b_ovld, b_ordy;
  logic [15:0] b_in1, b_in2, b_out;
  logic [3:0]  b_flags;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] bp_a [8];
  logic [31:0] bp_b [8];
  logic [35:0] bp_exp [8];
  logic [35:0] held;
  logic [31:0] rx, ry;
  logic        acc, prev_stall;
  int          sent, got_n, cyc, extra, stale;

  fp_multiply_pipe u_dut32 (
    .clk(clk), .reset(rst), .in_valid(a_vld), .in_ready(a_irdy),
    .IN1(a_in1), .IN2(a_in2), .out_valid(a_ovld), .out_ready(a_ordy),
    .OUT(a_out), .flags(a_flags)
  );

  fp_multiply_pipe #(.EXP_W(5), .MAN_W(10)) u_dut16 (
    .clk(clk), .reset(rst), .in_valid(b_vld), .in_ready(b_irdy),
    .IN1(b_in1), .IN2(b_in2), .out_valid(b_ovld), .out_ready(b_ordy),
    .OUT(b_out), .flags(b_flags)
  );

  // Reference: exact significand product in a double, then RNE to M bits by integer ops.
  function automatic logic [35:0] ref_mul(input int E, input int M,
                                          input logic [31:0] a, input logic [31:0] b);
    longint one, bias, emax, mmask, ea, eb, fa, fb, ed, f52, keep, rem, half, eres;
    longint sgn, qnan, infw;
    logic sa, sb, za, zb, ia, ib, na, nb, inex;
    logic [63:0] bits;
    real v;
    one   = 1;
    bias  = (one << (E - 1)) - 1;
    emax  = (one << E) - 1;
    mmask = (one << M) - 1;
    sa = a[E+M];
    sb = b[E+M];
    ea = (longint'(a) >> M) & emax;
    eb = (longint'(b) >> M) & emax;
    fa = longint'(a) & mmask;
    fb = longint'(b) & mmask;
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == emax) && (fa == 0);
    ib = (eb == emax) && (fb == 0);
    na = (ea == emax) && (fa != 0);
    nb = (eb == emax) && (fb != 0);
    sgn  = longint'(sa ^ sb) << (E + M);
    qnan = (emax << M) | (one << (M - 1));
    infw = sgn | (emax << M);
    if (na || nb) return {4'b0000, 32'(qnan)};
    if ((ia && zb) || (za && ib)) return {4'b1000, 32'(qnan)};
    if (ia || ib) return {4'b0000, 32'(infw)};
    if (za || zb) return {4'b0000, 32'(sgn)};
    v    = real'((one << M) | fa) * real'((one << M) | fb);
    bits = $realtobits(v);
    ed   = longint'(bits[62:52]) - 1023 + (ea - bias) + (eb - bias) - 2 * M;
    f52  = longint'(bits[51:0]);
    keep = f52 >> (52 - M);
    rem  = f52 & ((one << (52 - M)) - 1);
    half = one << (51 - M);
    inex = (rem != 0);
    if (rem > half || (rem == half && (keep & 1) == 1)) keep++;
    if (keep > mmask) begin
      keep = 0;
      ed++;
    end
    eres = ed + bias;
    if (eres >= emax) return {4'b0101, 32'(infw)};
    if (eres <= 0) return {4'b0011, 32'(sgn)};
    return {3'b000, inex, 32'(sgn | (eres << M) | keep)};
  endfunction

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  // Entered and left at 1ns after a rising edge, with out_ready held high.
  task automatic run_op(input string tag, input bit narrow, input logic [31:0] x,
                        input logic [31:0] y, input logic [35:0] exp_r);
    int lat;
    logic [35:0] got;
    if (narrow) begin
      b_in1 = x[15:0]; b_in2 = y[15:0]; b_vld = 1'b1; b_ordy = 1'b1;
    end else begin
      a_in1 = x; a_in2 = y; a_vld = 1'b1; a_ordy = 1'b1;
    end
    #1;
    check({tag, "_in_ready"}, 36'(narrow ? b_irdy : a_irdy), 36'(1));
    @(posedge clk); #1;
    a_vld = 1'b0;
    b_vld = 1'b0;
    lat = 0;
    while (lat < 8 && !(narrow ? b_ovld : a_ovld)) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 36'(lat), 36'(3));
    got = narrow ? {b_flags, 16'h0000, b_out} : {a_flags, a_out};
    check(tag, got, exp_r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_vld = 1'b0; a_ordy = 1'b0; a_in1 = '0; a_in2 = '0;
    b_vld = 1'b0; b_ordy = 1'b0; b_in1 = '0; b_in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 36'(a_ovld), 36'(0));
    check("rst_out_flags", {a_flags, a_out}, 36'(0));
    check("rst_out16", {b_ovld, b_flags, b_out}, 36'(0));
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 36'(a_irdy), 36'(1));

    run_op("basic",      0, 32'h415A0000, 32'hBE200000, {4'h0, 32'hC0084000});
    run_op("tie_even",   0, 32'h3F800001, 32'h3FC00000, {4'h1, 32'h3FC00002});
    run_op("near_one",   0, 32'h3F800001, 32'h3F800001, {4'h1, 32'h3F800002});
    run_op("inf_x_zero", 0, 32'h7F800000, 32'h00000000, {4'h8, 32'h7FC00000});
    run_op("overflow",   0, 32'h7F000000, 32'h40000000, {4'h5, 32'h7F800000});
    run_op("underflow",  0, 32'h00800000, 32'h3F000000, {4'h3, 32'h00000000});
    run_op("nan_in",     0, 32'h7FC00001, 32'h3F800000, {4'h0, 32'h7FC00000});
    run_op("inf_x_num",  0, 32'hFF800000, 32'h40000000, {4'h0, 32'hFF800000});
    run_op("daz_zero",   0, 32'h00000123, 32'hC0000000, {4'h0, 32'h80000000});
    run_op("narrow_1x-2", 1, 32'h00003C00, 32'h0000C000, {4'h0, 32'h0000C000});

    // Backpressure stream with random out_ready
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
      bp_b[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
      bp_exp[i] = ref_mul(8, 23, bp_a[i], bp_b[i]);
    end
    sent = 0; got_n = 0; cyc = 0; prev_stall = 1'b0; held = '0;
    @(posedge clk); #1;
    while (got_n < 8 && cyc < 300) begin
      a_ordy = 1'($urandom_range(0, 1));
      if (!a_vld && sent < 8) begin
        a_in1 = bp_a[sent]; a_in2 = bp_b[sent]; a_vld = 1'b1;
      end
      #1;
      if (prev_stall) begin
        check("bp_hold", {a_flags, a_out}, held);
        check("bp_hold_valid", 36'(a_ovld), 36'(1));
      end
      prev_stall = a_ovld && !a_ordy;
      if (prev_stall) begin
        held = {a_flags, a_out};
        check("bp_in_ready_low", 36'(a_irdy), 36'(0));
      end
      acc = a_vld && a_irdy;
      if (a_ovld && a_ordy) begin
        check($sformatf("bp_res%0d", got_n), {a_flags, a_out}, bp_exp[got_n]);
        got_n++;
      end
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        a_vld = 1'b0;
      end
      cyc++;
    end
    check("bp_count", 36'(got_n), 36'(8));
    a_ordy = 1'b1;
    a_vld  = 1'b0;
    extra  = 0;
    repeat (5) begin
      if (a_ovld) extra++;
      @(posedge clk); #1;
    end
    check("bp_no_dup", 36'(extra), 36'(0));

    // Reset between edges with results in flight
    for (int i = 0; i < 3; i++) begin
      a_in1 = 32'h40400000; a_in2 = 32'h3F800000 + 32'(i); a_vld = 1'b1;
      @(posedge clk); #1;
    end
    a_vld = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_pre_valid", 36'(a_ovld), 36'(1));
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", 36'(a_ovld), 36'(0));
    check("rst_mid_out", {a_flags, a_out}, 36'(0));
    #1 rst = 1'b0;
    @(posedge clk); #1;
    stale = 0;
    repeat (6) begin
      if (a_ovld) stale++;
      @(posedge clk); #1;
    end
    check("rst_mid_no_stale", 36'(stale), 36'(0));
    run_op("rst_mid_next", 0, 32'h40400000, 32'h40000000, {4'h0, 32'h40C00000});

    // Random sweeps
    for (int i = 0; i < 16; i++) begin
      rx = $urandom;
      ry = $urandom;
      if (i < 10) begin
        rx[30:23] = 8'($urandom_range(90, 165));
        ry[30:23] = 8'($urandom_range(90, 165));
      end
      run_op($sformatf("rnd32_%0d", i), 0, rx, ry, ref_mul(8, 23, rx, ry));
    end
    for (int i = 0; i < 16; i++) begin
      rx = {16'h0000, 16'($urandom)};
      ry = {16'h0000, 16'($urandom)};
      if (i < 10) begin
        rx[14:10] = 5'($urandom_range(8, 22));
        ry[14:10] = 5'($urandom_range(8, 22));
      end
      run_op($sformatf("rnd16_%0d", i), 1, rx, ry, ref_mul(5, 10, rx, ry));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
